rca_seq_ctrl: RTL and testbench
===============================

// Module: rca_seq_ctrl
// PURPOSE
//  Sequencer that reuses one external 4-bit ripple-carry adder slice to add or subtract WIDTH-bit operands, one nibble per cycle, LSB first.
//  It latches operands on a valid/ready handshake and drives the slice's x/y/c_in. It captures s/c_out into a result register and holds the carry between nibbles.
//  It sits between a requester (ALU/CPU datapath) and a single shared rca_4bit-style slice. It lets a WIDTH-bit add run on 4 bits of adder hardware.
// PARAMETERS
//  WIDTH    16   operand/result width in bits; must be a multiple of 4, >= 8
//  NIB      WIDTH/4 (localparam)   nibbles per operation = RUN cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      request present
//  in_ready   out  1      controller idle, request accepted when in_valid&&in_ready
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry-in (add mode only)
//  sub        in   1      1: A-B (B inverted, carry-in forced 1); 0: A+B+c_in
//  add_x      out  4      to slice x
//  add_y      out  4      to slice y
//  add_cin    out  1      to slice c_in
//  add_s      in   4      from slice s (combinational, same cycle)
//  add_cout   in   1      from slice c_out
//  out_valid  out  1      result held valid
//  out_ready  in   1      consumer accepts result when out_valid&&out_ready
//  sum        out  WIDTH  result
//  c_out      out  1      final carry-out (sub: 1 = no borrow)
//  ovf        out  1      two's-complement overflow
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, operand/result/carry regs=0; in_ready=1, out_valid=0, sum/c_out/ovf=0, add_x/add_y/add_cin=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1; slice inputs driven 0.
//   On in_valid: latch a_r=a, b_r=(sub ? ~b : b), cy=(sub ? 1 : c_in), idx=0; -> RUN.
//  RUN (exactly NIB cycles): in_ready=0. Drive the slice from nibble idx of the latched operands:
//   add_x=a_r[4*idx+:4], add_y=b_r[4*idx+:4], add_cin=cy.
//   Each edge: sum_r[4*idx+:4]<=add_s, cy<=add_cout, idx<=idx+1.
//   When idx==NIB-1: -> DONE.
//  DONE: out_valid=1; sum=sum_r, c_out=cy, ovf=(a_r[MSB]==b_r[MSB])&&(sum_r[MSB]!=a_r[MSB]). All outputs stable while waiting.
//   On out_ready: -> IDLE, out_valid=0 on the next cycle.
//  Latency: accept at edge T; out_valid rises after edge T+NIB, i.e. NIB+1 cycles after the accept cycle.
//   Throughput: one op per NIB+2 cycles with out_ready held high.
//  in_valid while not IDLE: ignored (in_ready=0); a/b/sub changes after accept have no effect.
//  out_ready while not DONE: ignored.
//  sum/c_out/ovf are don't-care-free: they hold the last result until the next DONE. They reset to 0.
//  idx wraps only via the RUN->DONE transition. No counter overflow state exists.
//  Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse is emitted.
// TESTING (WIDTH=16)
//  1. a=0x1234,b=0x4321,c_in=0,sub=0 -> after 4 RUN cycles out_valid=1, sum=0x5555, c_out=0, ovf=0.
//  2. a=0xFFFF,b=0x0001,c_in=0 -> carry ripples through all nibbles (add_cin=1 in RUN cycles 1..3); sum=0x0000, c_out=1, ovf=0.
//  3. sub=1,a=0x0005,b=0x0007 -> sum=0xFFFE, c_out=0, ovf=0. Separate op: sub=1,a=0x8000,b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
//  4. Handshake: hold out_ready=0 for 5 cycles in DONE -> sum/out_valid stable. Pulse in_valid during RUN -> ignored, in_ready=0. Back-to-back ops with out_ready=1 -> accepts 6 cycles apart.
//  5. Assert rst_n=0 in RUN cycle 2 -> all outputs 0 asynchronously, in_ready=1 after release. Next op 0x0F0F+0x00F1 -> sum=0x1000, c_out=0.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// Nibble-serial add/subtract sequencer driving one shared external 4-bit
// ripple-carry slice; the carry between nibbles is held in a register.
module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic [3:0]       add_x,
  output logic [3:0]       add_y,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cy;
  logic [WIDTH-1:0] sum_nxt;

  // Partial result with the slice's current nibble merged in, so the final
  // edge can publish the complete sum without an extra cycle.
  always_comb begin
    sum_nxt = sum_r;
    sum_nxt[4*idx +: 4] = add_s;
  end

  assign add_x   = (state == RUN) ? a_r[4*idx +: 4] : 4'h0;
  assign add_y   = (state == RUN) ? b_r[4*idx +: 4] : 4'h0;
  assign add_cin = (state == RUN) ? cy : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      cy        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            cy       <= sub ? 1'b1 : c_in;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_r <= sum_nxt;
          cy    <= add_cout;
          if (idx == LAST) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= sum_nxt;
            c_out     <= add_cout;
            // b_r already holds ~b for subtraction, so one rule covers both modes
            ovf       <= (a_r[MSB] == b_r[MSB]) && (sum_nxt[MSB] != a_r[MSB]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (WIDTH=16) with a behavioural 4-bit slice.
module tb_rca_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic [3:0]  add_x;
  logic [3:0]  add_y;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External ripple-carry slice: purely combinational.
  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};

  rca_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepts one op, walks the RUN cycles collecting add_cin, ends in DONE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic ts, input bit poke,
                        output logic [3:0] cins);
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1;
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; c_in = ~tc; sub = ~ts;
    for (int i = 0; i < 4; i++) begin
      cins[i] = add_cin;
      check("run_busy", {30'b0, in_ready, out_valid}, 32'd0);
      in_valid = (poke && i == 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("done_valid", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_done", {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  logic [3:0]  cins;
  logic [15:0] held;
  int          acc [$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #12;
    check("rst_outs", {in_ready, out_valid, c_out, ovf, add_cin, add_x, add_y, sum},
          {1'b1, 4'b0, 4'h0, 4'h0, 16'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. plain add
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, cins);
    check("t1_sum", {15'b0, c_out, ovf, sum}, {15'b0, 1'b0, 1'b0, 16'h5555});
    check("t1_cins", {28'b0, cins}, 32'h0);
    finish_op();

    // 2. carry ripples through every nibble
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, cins);
    check("t2_sum", {15'b0, c_out, ovf, sum}, {15'b0, 1'b1, 1'b0, 16'h0000});
    check("t2_cins", {28'b0, cins}, 32'hE);
    finish_op();

    // 3. subtraction, borrow and overflow cases
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, cins);
    check("t3a_sum", {15'b0, c_out, ovf, sum}, {15'b0, 1'b0, 1'b0, 16'hFFFE});
    check("t3a_cin0", {31'b0, cins[0]}, 32'd1);
    finish_op();
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, cins);
    check("t3b_sum", {15'b0, c_out, ovf, sum}, {15'b0, 1'b1, 1'b1, 16'h7FFF});
    finish_op();

    // 4a. stall in DONE, with a request poked during RUN
    run_op(16'h7000, 16'h1000, 1'b1, 1'b0, 1'b1, cins);
    check("t4_sum", {15'b0, c_out, ovf, sum}, {15'b0, 1'b0, 1'b1, 16'h8001});
    held = sum;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold", {14'b0, out_valid, in_ready, sum}, {14'b0, 1'b1, 1'b0, held});
    end
    finish_op();

    // 4b. back-to-back ops with both handshakes held high
    a = 16'h0001; b = 16'h0001; c_in = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (in_valid && in_ready) acc.push_back(cyc);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("t4_acc_cnt", acc.size(), 32'd3);
    if (acc.size() >= 3) begin
      check("t4_gap1", acc[1] - acc[0], 32'd6);
      check("t4_gap2", acc[2] - acc[1], 32'd6);
    end
    for (int i = 0; i < 8 && !(in_ready && !out_valid); i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("t4_drained", {30'b0, in_ready, out_valid}, 32'd2);

    // 5. reset in the middle of RUN
    a = 16'hAAAA; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", {in_ready, out_valid, c_out, ovf, add_cin, add_x, add_y, sum},
          {1'b1, 4'b0, 4'h0, 4'h0, 16'h0});
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      check("t5_no_valid", {30'b0, in_ready, out_valid}, 32'd2);
      @(posedge clk); #1;
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, cins);
    check("t5_sum", {15'b0, c_out, ovf, sum}, {15'b0, 1'b0, 1'b0, 16'h1000});
    finish_op();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
